downsamp_mph: RTL and testbench

//  Multi-channel decimator with its own phase counter and runtime phase select.

---
 rtl/downsamp_mph.sv | 159 +++++++++++++++
 tb/tb_downsamp_mph.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/downsamp_mph.sv
// downsamp_mph: multi-channel decimator with an internal phase counter and a
// runtime-selectable capture phase. One sample set is kept out of every OS
// valid input samples. All NCH channels are captured together and passed
// through bit-exact.
// Optional feature macro: DOWNSAMP_PHASE_EST_EN adds a max-energy phase
// estimator. Its result is advisory and never changes the capture phase.
module downsamp_mph #(
    parameter int NBT_IN_OUT = 8,
    parameter int NBF_IN_OUT = 7,
    parameter int NCH        = 2,
    parameter int OS         = 4,
    parameter int LOG2_WIN   = 10,
    localparam int NB_PH     = $clog2(OS)
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [NCH*NBT_IN_OUT-1:0] i_is_data,
    input  logic                      i_valid,
    input  logic [NB_PH-1:0]          i_phase,
    input  logic                      i_phase_ld,
`ifdef DOWNSAMP_PHASE_EST_EN
    output logic [NB_PH-1:0]          o_best_phase,
    output logic                      o_best_vld,
`endif
    output logic [NCH*NBT_IN_OUT-1:0] o_os_data,
    output logic                      o_valid
);

    localparam logic [NB_PH-1:0] PH_MAX = NB_PH'(OS - 1);
    localparam logic [NB_PH:0]   OS_EXT = (NB_PH + 1)'(OS);

    logic [NB_PH-1:0]          cnt_q, cnt_d;
    logic [NB_PH-1:0]          phase_q, phase_d;
    logic [NCH*NBT_IN_OUT-1:0] os_data_q;
    logic                      valid_q;
    logic                      capture;

    // Next-state for the phase counter and phase register; capture uses the old phase.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d   = cnt_q;
        phase_d = phase_q;
        capture = i_valid && (cnt_q == phase_q);
        if (i_valid) begin
            cnt_d = (cnt_q == PH_MAX) ? '0 : cnt_q + 1'b1;
        end
        if (i_phase_ld) begin
            phase_d = ({1'b0, i_phase} >= OS_EXT) ? PH_MAX : i_phase;
        end
    end

    // Counter, phase register and registered decimated output.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            os_data_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            valid_q <= capture;
            if (capture) begin
                os_data_q <= i_is_data;
            end
        end
    end

    assign o_os_data = os_data_q;
    assign o_valid   = valid_q;

`ifdef DOWNSAMP_PHASE_EST_EN
    localparam int NB_ACC = NBT_IN_OUT + $clog2(NCH) + LOG2_WIN;

    logic [NB_ACC-1:0]   acc_q [OS];
    logic [NB_ACC-1:0]   acc_d [OS];
    logic [NB_ACC-1:0]   energy;
    logic [NB_ACC-1:0]   best_val;
    logic [NB_PH-1:0]    best_idx;
    logic [LOG2_WIN-1:0] sym_q;
    logic [NB_PH-1:0]    best_phase_q;
    logic                best_vld_q;
    logic                sym_end;
    logic                win_end;

    // Sum of saturated magnitudes across channels; -2^(N-1) maps to 2^(N-1)-1.
    always_comb begin : energy_calc
        logic [NBT_IN_OUT-1:0] smp;
        logic [NBT_IN_OUT-2:0] mag;
        energy = '0;
        smp    = '0;
        mag    = '0;
        for (int k = 0; k < NCH; k++) begin
            smp = i_is_data[k*NBT_IN_OUT +: NBT_IN_OUT];
            if (smp == {1'b1, {(NBT_IN_OUT-1){1'b0}}}) begin
                mag = '1;
            end else if (smp[NBT_IN_OUT-1]) begin
                mag = (NBT_IN_OUT-1)'(-smp);
            end else begin
                mag = smp[NBT_IN_OUT-2:0];
            end
            energy = energy + NB_ACC'(mag);
        end
    end

    // Accumulators including the current add, and argmax with ties to the lowest index.
    always_comb begin
        for (int k = 0; k < OS; k++) begin
            acc_d[k] = acc_q[k] + ((NB_PH'(k) == cnt_q) ? energy : '0);
        end
        best_idx = '0;
        best_val = acc_d[0];
        for (int k = 1; k < OS; k++) begin
            if (acc_d[k] > best_val) begin
                best_val = acc_d[k];
                best_idx = NB_PH'(k);
            end
        end
    end

    assign sym_end = i_valid && (cnt_q == PH_MAX);
    assign win_end = sym_end && (sym_q == '1);

    // Energy accumulation per phase, window bookkeeping and result reporting.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: the accumulator array is reset explicitly; the first window must start from zero.
            for (int k = 0; k < OS; k++) begin
                acc_q[k] <= '0;
            end
            sym_q        <= '0;
            best_phase_q <= '0;
            best_vld_q   <= 1'b0;
        end else begin
            best_vld_q <= 1'b0;
            if (win_end) begin
                for (int k = 0; k < OS; k++) begin
                    acc_q[k] <= '0;
                end
                sym_q        <= '0;
                best_phase_q <= best_idx;
                best_vld_q   <= 1'b1;
            end else if (i_valid) begin
                for (int k = 0; k < OS; k++) begin
                    acc_q[k] <= acc_d[k];
                end
                if (sym_end) begin
                    sym_q <= sym_q + 1'b1;
                end
            end
        end
    end

    assign o_best_phase = best_phase_q;
    assign o_best_vld   = best_vld_q;
`endif

endmodule

// File: tb/tb_downsamp_mph.sv
// Self-checking bench for downsamp_mph (OS=4, NCH=2, 8-bit samples).
// A reference model predicts each capture; expected words are queued when the
// stimulus is driven and compared when o_valid fires. The estimator section is
// built only when DOWNSAMP_PHASE_EST_EN is defined.
module tb_downsamp_mph;

    localparam int NBT   = 8;
    localparam int NCH   = 2;
    localparam int OS    = 4;
    localparam int NB_PH = 2;
    localparam int DW    = NCH * NBT;

    logic             clk = 1'b0;
    logic             i_reset = 1'b0;
    logic [DW-1:0]    i_is_data = '0;
    logic             i_valid = 1'b0;
    logic [NB_PH-1:0] i_phase = '0;
    logic             i_phase_ld = 1'b0;
    logic [DW-1:0]    o_os_data;
    logic             o_valid;
`ifdef DOWNSAMP_PHASE_EST_EN
    logic [NB_PH-1:0] o_best_phase;
    logic             o_best_vld;
`endif

    downsamp_mph #(
        .NBT_IN_OUT(NBT), .NBF_IN_OUT(7), .NCH(NCH), .OS(OS), .LOG2_WIN(2)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_is_data(i_is_data), .i_valid(i_valid),
        .i_phase(i_phase), .i_phase_ld(i_phase_ld),
`ifdef DOWNSAMP_PHASE_EST_EN
        .o_best_phase(o_best_phase), .o_best_vld(o_best_vld),
`endif
        .o_os_data(o_os_data), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0]    exp_q [$];
    logic [NB_PH-1:0] m_cnt = '0;
    logic [NB_PH-1:0] m_phase = '0;
    logic [DW-1:0]    m_hold = '0;
    logic             exp_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts capture with the old phase.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ld,
                        input logic [NB_PH-1:0] ph);
        logic cap;
        i_valid    = v;
        i_is_data  = d;
        i_phase_ld = ld;
        i_phase    = ph;
        cap = v && (m_cnt == m_phase);
        if (cap) exp_q.push_back(d);
        if (v) m_cnt = (int'(m_cnt) == OS - 1) ? '0 : m_cnt + 1'b1;
        if (ld) m_phase = (int'(ph) >= OS) ? NB_PH'(OS - 1) : ph;
        @(posedge clk);
        #1;
        exp_vld = cap;
        if (cap) m_hold = d;
    endtask

    task automatic reset_dut();
        i_valid    = 1'b0;
        i_phase_ld = 1'b0;
        i_reset    = 1'b0;
        exp_vld    = 1'b0;
        m_hold     = '0;
        m_cnt      = '0;
        m_phase    = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        i_reset = 1'b1;
    endtask

    // Scoreboard side: every negedge checks the strobe, held data and queue.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        check("o_valid", 32'(o_valid), 32'(exp_vld));
        check("o_os_data_hold", 32'(o_os_data), 32'(m_hold));
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(o_os_data), 32'(e));
            end
        end
    end

    typedef struct {
        logic             v;
        logic [DW-1:0]    d;
        logic             ld;
        logic [NB_PH-1:0] ph;
        logic             exp_v;
        logic [DW-1:0]    exp_d;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase-load sequence from reset (cnt=0, phase=0). 2'd3 stands for a
        // request of 7: the 2-bit port already limits it to OS-1.
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 2'd1, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 16'h0010, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 16'h0011, 1'b1, 2'd3, 1'b1, 16'h0011};
        tbl[3] = '{1'b1, 16'h0012, 1'b0, 2'd0, 1'b0, 16'h0011};
        tbl[4] = '{1'b1, 16'h0013, 1'b0, 2'd0, 1'b1, 16'h0013};
        tbl[5] = '{1'b1, 16'h0014, 1'b1, 2'd0, 1'b0, 16'h0013};
        tbl[6] = '{1'b1, 16'h0015, 1'b1, 2'd3, 1'b0, 16'h0013};
        tbl[7] = '{1'b1, 16'h0016, 1'b0, 2'd0, 1'b0, 16'h0013};
        tbl[8] = '{1'b1, 16'h0017, 1'b0, 2'd0, 1'b1, 16'h0017};
        tbl[9] = '{1'b0, 16'h0099, 1'b0, 2'd0, 1'b0, 16'h0017};

        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_os_data), 32'd0);
        reset_dut();

        // Phase 0, valid every clock, ramp on ch0: captures 0,4,8,...
        for (int k = 0; k < 16; k++) step(1'b1, {8'(k * 3), 8'(k)}, 1'b0, '0);

        // Phase 2, valid one clock in three: captures 2,6,10.
        reset_dut();
        step(1'b0, '0, 1'b1, 2'd2);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, {8'h00, 8'(k)}, 1'b0, '0);
            step(1'b0, 16'hDEAD, 1'b0, '0);
            step(1'b0, 16'hBEEF, 1'b0, '0);
        end

        // Table-driven phase-load sequence with explicit expected outputs.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].ld, tbl[i].ph);
            check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_v));
            check($sformatf("tbl%0d_data", i), 32'(o_os_data), 32'(tbl[i].exp_d));
        end

        // Reset asserted between a capture and its update edge.
        reset_dut();
        step(1'b1, 16'h0101, 1'b0, '0);
        for (int k = 0; k < 3; k++) step(1'b1, 16'h0202, 1'b0, '0);
        i_valid   = 1'b1;
        i_is_data = 16'h5A5A;
        #2;
        i_reset = 1'b0;
        exp_vld = 1'b0;
        m_hold  = '0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_data", 32'(o_os_data), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_data", 32'(o_os_data), 32'd0);
        m_cnt   = '0;
        m_phase = '0;
        exp_q.delete();
        i_reset = 1'b1;
        step(1'b1, 16'h3333, 1'b0, '0);
        check("post_rst_first", 32'(o_os_data), 32'h3333);
        step(1'b1, 16'h4444, 1'b0, '0);

        // Two channels at phase 1: +127 on ch0 and -128 on ch1 captured together.
        reset_dut();
        step(1'b0, '0, 1'b1, 2'd1);
        step(1'b1, 16'h1111, 1'b0, '0);
        step(1'b1, 16'h807F, 1'b0, '0);
        step(1'b1, 16'h2222, 1'b0, '0);
        check("pack_exact", 32'(o_os_data), 32'h807F);

        // Random traffic with occasional phase loads.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 15) == 0),
                 NB_PH'($urandom));
        end
        step(1'b0, '0, 1'b0, '0);

`ifdef DOWNSAMP_PHASE_EST_EN
        // Window 1: phase 2 carries +-100, others +-10 -> best 2.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            int lvl;
            lvl = (i % 4 == 2) ? 100 : 10;
            step(1'b1, {8'(-lvl), 8'(lvl)}, 1'b0, '0);
            check("est1_vld", 32'(o_best_vld), 32'(i == 15));
        end
        check("est1_phase", 32'(o_best_phase), 32'd2);
        // Window 2: phases 1 and 3 equal -> lowest index 1 (also needs a cleared window).
        for (int i = 0; i < 16; i++) begin
            int lvl;
            lvl = (i % 4 == 1 || i % 4 == 3) ? 50 : 10;
            step(1'b1, {8'(lvl), 8'(-lvl)}, 1'b0, '0);
            check("est2_vld", 32'(o_best_vld), 32'(i == 15));
        end
        check("est2_phase", 32'(o_best_phase), 32'd1);
        // Window 3: phase 0 at +127, phase 1 at -128 (saturates to 127) -> tie, best 0.
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] d;
            d = (i % 4 == 0) ? 16'h7F7F : (i % 4 == 1) ? 16'h8080 : 16'h0101;
            step(1'b1, d, 1'b0, '0);
            check("est3_vld", 32'(o_best_vld), 32'(i == 15));
        end
        check("est3_phase", 32'(o_best_phase), 32'd0);
`endif

        step(1'b0, '0, 1'b0, '0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
